gmii_rx_framer: RTL and testbench

//  GMII receive front-end with frame delineation: samples eth_rxd/eth_rxdv/eth_rxer on a selectable eth_rxc edge.

---
 rtl/gmii_rx_framer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: GMII receive front-end. Registers the PHY pins on the
// selected eth_rxc edge, strips the 0x55 preamble and 0xD5 SFD, and emits
// the DA..FCS bytes as a framed stream with sop/eop/err, length and a
// saturating count of dropped or errored frames.
// Optional build macro RX_CRC_CHECK_EN adds an Ethernet CRC-32 residue check
// whose failure marks the frame bad at eop.
module gmii_rx_framer #(
  parameter bit SAMPLE_NEGEDGE = 1'b1,
  parameter int PREAMBLE_MIN   = 2,
  parameter int MIN_FRAME      = 64,
  parameter int MAX_FRAME      = 1522,
  parameter int CNT_W          = 16
) (
  input  logic             eth_rxc,
  input  logic             rst_n,
  input  logic             eth_rxdv,
  input  logic             eth_rxer,
  input  logic [7:0]       eth_rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sop,
  output logic             rx_eop,
  output logic             rx_err,
  output logic [CNT_W-1:0] rx_len,
  output logic [CNT_W-1:0] rx_drop_cnt
);

  localparam logic [7:0]       PRE_BYTE  = 8'h55;
  localparam logic [7:0]       SFD_BYTE  = 8'hD5;
  localparam logic [2:0]       PRE_MIN_C = 3'(PREAMBLE_MIN);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_FRAME);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_FRAME);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  // Every flop in the block runs on this clock; the edge is a build-time choice.
  logic clk_s;
  generate
    if (SAMPLE_NEGEDGE) begin : g_neg
      assign clk_s = ~eth_rxc;
    end else begin : g_pos
      assign clk_s = eth_rxc;
    end
  endgenerate

  // Reset synchroniser: assertion is immediate, release lands on clk_s.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Input stage s1: pins registered every edge; the FSM only looks at s1.
  logic       s1_dv_q, s1_er_q;
  logic [7:0] s1_d_q;
  always_ff @(posedge clk_s or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s1_dv_q <= 1'b0;
      s1_er_q <= 1'b0;
      s1_d_q  <= 8'h00;
    end else begin
      s1_dv_q <= eth_rxdv;
      s1_er_q <= eth_rxer;
      s1_d_q  <= eth_rxd;
    end
  end

  state_t           state_q, state_d;
  logic [2:0]       pcnt_q, pcnt_d;
  logic [7:0]       h_q, h_d;
  logic             h_full_q, h_full_d;
  logic             sop_pend_q, sop_pend_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             err_o_q, err_o_d;
  logic [CNT_W-1:0] len_o_q, len_o_d;
  logic             drop_inc;
  logic             frame_err;
  logic             crc_bad;

`ifdef RX_CRC_CHECK_EN
  // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), one byte per edge.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic [31:0] crc_q, crc_d;

  // The register holds the reflected CRC, so the good-frame residue is
  // compared after reversing back to the MSB-first constant.
  assign crc_bad = (bitrev32(crc_q) != 32'hC704DD7B);

  // CRC accumulator, restarted at every SFD.
  always_ff @(posedge clk_s or negedge rst_int_n) begin
    if (!rst_int_n) crc_q <= 32'hFFFFFFFF;
    else            crc_q <= crc_d;
  end
`else
  assign crc_bad = 1'b0;
`endif

  // Frame FSM: preamble qualification, hold-register data path, eop tagging.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    h_d        = h_q;
    h_full_d   = h_full_q;
    sop_pend_d = sop_pend_q;
    err_d      = err_q;
    len_d      = len_q;
    data_d     = data_q;
    len_o_d    = len_o_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    err_o_d    = 1'b0;
    drop_inc   = 1'b0;
    frame_err  = 1'b0;
`ifdef RX_CRC_CHECK_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (s1_dv_q) begin
          if (s1_d_q == PRE_BYTE) begin
            state_d = S_PRE;
            pcnt_d  = 3'd1;
          end else begin
            // Frame started mid-stream: discard it silently.
            state_d = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!s1_dv_q) begin
          state_d = S_IDLE;
        end else if (s1_d_q == PRE_BYTE) begin
          if (pcnt_q != 3'd7) pcnt_d = pcnt_q + 3'd1;
        end else if (s1_d_q == SFD_BYTE && pcnt_q >= PRE_MIN_C) begin
          state_d    = S_DATA;
          h_full_d   = 1'b0;
          sop_pend_d = 1'b1;
          err_d      = 1'b0;
          len_d      = '0;
`ifdef RX_CRC_CHECK_EN
          crc_d      = 32'hFFFFFFFF;
`endif
        end else begin
          state_d  = S_DROP;
          drop_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (!s1_dv_q) begin
          // End of frame: flush the held byte tagged eop. An empty frame
          // (SFD then dv low) still gets a single sop/eop/err pulse.
          frame_err  = err_q | ~h_full_q | (len_q < MIN_C) | crc_bad;
          valid_d    = 1'b1;
          sop_d      = sop_pend_q;
          eop_d      = 1'b1;
          err_o_d    = frame_err;
          data_d     = h_full_q ? h_q : 8'h00;
          len_o_d    = len_q;
          drop_inc   = frame_err;
          sop_pend_d = 1'b0;
          h_full_d   = 1'b0;
          state_d    = S_IDLE;
        end else if (len_q == MAX_C) begin
          // Oversize: close the frame at the limit, discard the rest.
          valid_d    = 1'b1;
          sop_d      = sop_pend_q;
          eop_d      = 1'b1;
          err_o_d    = 1'b1;
          data_d     = h_q;
          len_o_d    = len_q;
          drop_inc   = 1'b1;
          sop_pend_d = 1'b0;
          h_full_d   = 1'b0;
          state_d    = S_DROP;
        end else begin
          if (h_full_q) begin
            valid_d    = 1'b1;
            sop_d      = sop_pend_q;
            sop_pend_d = 1'b0;
            data_d     = h_q;
          end
          h_d      = s1_d_q;
          h_full_d = 1'b1;
          len_d    = len_q + CNT_W'(1);
          err_d    = err_q | s1_er_q;
`ifdef RX_CRC_CHECK_EN
          crc_d    = crc_byte(crc_q, s1_d_q);
`endif
        end
      end
      S_DROP: begin
        if (!s1_dv_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drop counter saturates at all-ones.
  always_comb begin
    drop_d = drop_q;
    if (drop_inc && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk_s or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= S_IDLE;
      pcnt_q     <= 3'd0;
      h_q        <= 8'h00;
      h_full_q   <= 1'b0;
      sop_pend_q <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
      drop_q     <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_o_q    <= 1'b0;
      len_o_q    <= '0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      h_q        <= h_d;
      h_full_q   <= h_full_d;
      sop_pend_q <= sop_pend_d;
      err_q      <= err_d;
      len_q      <= len_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      err_o_q    <= err_o_d;
      len_o_q    <= len_o_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_sop      = sop_q;
  assign rx_eop      = eop_q;
  assign rx_err      = err_o_q;
  assign rx_len      = len_o_q;
  assign rx_drop_cnt = drop_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb_gmii_rx_framer: frame-level vector table, hand sequences for latency,
// back-to-back and mid-frame reset, then random frames scored against a
// wire-level reference model.
module tb_gmii_rx_framer;

  localparam int PMIN = 2;
  localparam int MINF = 64;
  localparam int MAXF = 1522;

  logic        eth_rxc = 1'b0;
  logic        rst_n   = 1'b1;
  logic        eth_rxdv = 1'b0;
  logic        eth_rxer = 1'b0;
  logic [7:0]  eth_rxd  = 8'h00;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sop, rx_eop, rx_err;
  logic [15:0] rx_len, rx_drop_cnt;

  gmii_rx_framer #(
    .SAMPLE_NEGEDGE(1'b1), .PREAMBLE_MIN(PMIN), .MIN_FRAME(MINF),
    .MAX_FRAME(MAXF), .CNT_W(16)
  ) dut (
    .eth_rxc(eth_rxc), .rst_n(rst_n), .eth_rxdv(eth_rxdv), .eth_rxer(eth_rxer),
    .eth_rxd(eth_rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop),
    .rx_eop(rx_eop), .rx_err(rx_err), .rx_len(rx_len), .rx_drop_cnt(rx_drop_cnt)
  );

  always #4 eth_rxc = ~eth_rxc;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Wire image of the frame being driven, and its payload.
  logic [7:0] wq[$];
  logic       eq[$];
  logic [7:0] pay[$];
  logic       per[$];
  int         mark = -1;
  int unsigned drv_cyc = 0;

  // Expected stream for the scored phase.
  logic [7:0] exp_b[$];
  int         exp_n[$];
  int         exp_len[$];
  logic       exp_err[$];
  int         model_drop = 0;
  logic       chk_stream = 1'b0;

  // Monitor statistics (written only by the monitor).
  int unsigned cyc = 0;
  int          st_valid = 0, st_sop = 0, st_eop = 0;
  logic [7:0]  st_sop_data = 8'h00, st_last = 8'h00;
  int          st_len = 0;
  logic        st_err = 1'b0;
  int unsigned sop_cyc = 0;
  int          mcnt = 0;

  initial forever begin
    @(negedge eth_rxc);
    cyc++;
  end

  // Outputs move on the negedge; they are sampled on the posedge.
  initial forever begin
    @(posedge eth_rxc);
    if (!rst_n) mcnt = 0;
    if (rx_valid) begin
      st_valid++;
      st_last = rx_data;
      if (rx_sop) begin st_sop++; st_sop_data = rx_data; sop_cyc = cyc; end
      if (rx_eop) begin st_eop++; st_len = rx_len; st_err = rx_err; end
      if (chk_stream) begin
        if (exp_n.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("stream_data", rx_data, exp_b.pop_front());
          check("stream_sop", rx_sop, (mcnt == 0));
          check("stream_eop", rx_eop, (mcnt == exp_n[0] - 1));
          if (rx_eop) begin
            check("stream_len", rx_len, exp_len.pop_front());
            check("stream_err", rx_err, exp_err.pop_front());
            void'(exp_n.pop_front());
            mcnt = 0;
          end else begin
            mcnt++;
          end
        end
      end
    end
  end

`ifdef RX_CRC_CHECK_EN
  // Standard Ethernet CRC over q[s .. s+cnt-1], final value inverted.
  function automatic logic [31:0] crc32(input logic [7:0] q[$], input int s, input int cnt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      c = c ^ {24'h0, q[s+i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // FCS is sent least-significant byte first.
  function automatic logic fcs_ok(input logic [7:0] q[$], input int s, input int len);
    logic [31:0] c;
    c = crc32(q, s, len - 4);
    return {q[s+len-1], q[s+len-2], q[s+len-3], q[s+len-4]} == c;
  endfunction
`endif

  task automatic make_pay(input int plen, input int er_idx, input logic rnd, input logic fcs);
    pay.delete(); per.delete();
    for (int i = 0; i < plen; i++) begin
      pay.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i));
      per.push_back(i == er_idx);
    end
`ifdef RX_CRC_CHECK_EN
    if (fcs && plen >= 4 && plen <= MAXF) begin
      logic [31:0] c;
      c = crc32(pay, 0, plen - 4);
      pay[plen-4] = c[7:0];   pay[plen-3] = c[15:8];
      pay[plen-2] = c[23:16]; pay[plen-1] = c[31:24];
    end
`else
    if (fcs) mark = mark;
`endif
  endtask

  task automatic build_wire(input int npre, input logic [7:0] sfd);
    wq.delete(); eq.delete();
    for (int i = 0; i < npre; i++) begin wq.push_back(8'h55); eq.push_back(1'b0); end
    wq.push_back(sfd); eq.push_back(1'b0);
    foreach (pay[i]) begin wq.push_back(pay[i]); eq.push_back(per[i]); end
  endtask

  task automatic drive(input int gap);
    for (int i = 0; i < wq.size(); i++) begin
      @(posedge eth_rxc);
      eth_rxdv = 1'b1; eth_rxd = wq[i]; eth_rxer = eq[i];
      if (i == mark) drv_cyc = cyc;
    end
    for (int i = 0; i < gap; i++) begin
      @(posedge eth_rxc);
      eth_rxdv = 1'b0; eth_rxd = 8'h00; eth_rxer = 1'b0;
    end
  endtask

  // Reference model: interpret the wire image by the framing rules.
  task automatic model_push();
    int n, len, outn;
    logic err;
    n = 0;
    while (n < wq.size() && wq[n] == 8'h55) n++;
    if (n == 0 || n == wq.size()) return;
    if (wq[n] != 8'hD5 || ((n > 7) ? 7 : n) < PMIN) begin model_drop++; return; end
    len  = wq.size() - n - 1;
    outn = (len == 0) ? 1 : ((len > MAXF) ? MAXF : len);
    err  = (len < MINF) || (len > MAXF);
    for (int k = 0; k < outn; k++) begin
      if (len == 0) exp_b.push_back(8'h00);
      else begin
        exp_b.push_back(wq[n+1+k]);
        if (eq[n+1+k]) err = 1'b1;
      end
    end
`ifdef RX_CRC_CHECK_EN
    if (len >= 4 && len <= MAXF && !fcs_ok(wq, n + 1, len)) err = 1'b1;
`endif
    exp_n.push_back(outn);
    exp_len.push_back((len == 0) ? 0 : outn);
    exp_err.push_back(err);
    if (err) model_drop++;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_sop"},   rx_sop,   0);
    check({tag, "_eop"},   rx_eop,   0);
    check({tag, "_err"},   rx_err,   0);
    check({tag, "_data"},  rx_data,  0);
    check({tag, "_len"},   rx_len,   0);
    check({tag, "_drop"},  rx_drop_cnt, 0);
  endtask

  typedef struct {
    int         npre;
    logic [7:0] sfd;
    int         plen;
    int         er_idx;
    int         exp_valid;
    int         exp_len;   // -1: no eop expected
    logic       exp_err;
    int         exp_drop;  // drop-count increment
  } vec_t;

  vec_t tbl[12];
  int   exp_drop_tot;
  int   b_valid, b_eop, b_sop;

  initial begin
    tbl[0]  = '{7, 8'hD5,   64, -1,   64,   64, 1'b0, 0};
    tbl[1]  = '{7, 8'hD5,   64, 10,   64,   64, 1'b1, 1};
    tbl[2]  = '{1, 8'hD5,   64, -1,    0,   -1, 1'b0, 1};
    tbl[3]  = '{2, 8'hD5,   64, -1,   64,   64, 1'b0, 0};
    tbl[4]  = '{7, 8'hD5,   40, -1,   40,   40, 1'b1, 1};
    tbl[5]  = '{7, 8'hD5, 1600, -1, 1522, 1522, 1'b1, 1};
    tbl[6]  = '{7, 8'hD5, 1522, -1, 1522, 1522, 1'b0, 0};
    tbl[7]  = '{7, 8'hD5,   63, -1,   63,   63, 1'b1, 1};
    tbl[8]  = '{7, 8'hD5,    0, -1,    1,    0, 1'b1, 1};
    tbl[9]  = '{5, 8'h5D,   64, -1,    0,   -1, 1'b0, 1};
    tbl[10] = '{0, 8'hD5,   64, -1,    0,   -1, 1'b0, 0};
    tbl[11] = '{3, 8'hD5,   65, 64,   65,   65, 1'b1, 1};

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) @(posedge eth_rxc);
    chk_zero("rst_init");
    rst_n = 1'b1;
    repeat (4) @(posedge eth_rxc);

    // Frame-level vectors.
    exp_drop_tot = 0;
    for (int v = 0; v < 12; v++) begin
      make_pay(tbl[v].plen, tbl[v].er_idx, 1'b0, 1'b1);
      build_wire(tbl[v].npre, tbl[v].sfd);
      mark = tbl[v].npre + 1;
      b_valid = st_valid; b_eop = st_eop; b_sop = st_sop;
      exp_drop_tot += tbl[v].exp_drop;
      drive(8);
      check($sformatf("vec%0d_valid", v), st_valid - b_valid, tbl[v].exp_valid);
      check($sformatf("vec%0d_eop", v), st_eop - b_eop, (tbl[v].exp_len >= 0) ? 1 : 0);
      check($sformatf("vec%0d_sop", v), st_sop - b_sop, (tbl[v].exp_len >= 0) ? 1 : 0);
      if (tbl[v].exp_len >= 0) begin
        check($sformatf("vec%0d_len", v), st_len, tbl[v].exp_len);
        check($sformatf("vec%0d_err", v), st_err, tbl[v].exp_err);
        check($sformatf("vec%0d_first", v), st_sop_data, (tbl[v].plen == 0) ? 0 : pay[0]);
        check($sformatf("vec%0d_last", v), st_last,
              (tbl[v].plen == 0) ? 0 : pay[tbl[v].exp_valid - 1]);
      end
      check($sformatf("vec%0d_drop", v), rx_drop_cnt, exp_drop_tot);
      if (v == 0) check("latency", sop_cyc - drv_cyc, 3);
    end
    mark = -1;

`ifdef RX_CRC_CHECK_EN
    // Corrupted FCS.
    make_pay(64, -1, 1'b0, 1'b1);
    pay[63] = pay[63] ^ 8'h01;
    build_wire(7, 8'hD5);
    b_eop = st_eop;
    exp_drop_tot++;
    drive(8);
    check("crc_eop", st_eop - b_eop, 1);
    check("crc_err", st_err, 1);
    check("crc_drop", rx_drop_cnt, exp_drop_tot);
`endif

    // Back-to-back frames with a one-cycle dv gap.
    make_pay(64, -1, 1'b0, 1'b1);
    build_wire(7, 8'hD5);
    b_valid = st_valid; b_eop = st_eop;
    drive(1);
    drive(8);
    check("b2b_valid", st_valid - b_valid, 128);
    check("b2b_eop", st_eop - b_eop, 2);
    check("b2b_err", st_err, 0);
    check("b2b_drop", rx_drop_cnt, exp_drop_tot);

    // Reset at payload byte 20 of a third frame.
    for (int i = 0; i < 8 + 20; i++) begin
      @(posedge eth_rxc);
      eth_rxdv = 1'b1; eth_rxd = wq[i]; eth_rxer = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    b_valid = st_valid;
    for (int i = 8 + 20; i < wq.size(); i++) begin
      @(posedge eth_rxc);
      eth_rxdv = 1'b1; eth_rxd = wq[i];
      if (i == 8 + 23) rst_n = 1'b1;
    end
    repeat (8) begin
      @(posedge eth_rxc);
      eth_rxdv = 1'b0; eth_rxd = 8'h00;
    end
    check("rst_tail_valid", st_valid - b_valid, 0);
    check("rst_tail_drop", rx_drop_cnt, 0);
    b_valid = st_valid; b_eop = st_eop;
    drive(8);
    check("rst_next_valid", st_valid - b_valid, 64);
    check("rst_next_eop", st_eop - b_eop, 1);
    check("rst_next_len", st_len, 64);
    check("rst_next_err", st_err, 0);

    // Random frames against the model.
    @(posedge eth_rxc);
    rst_n = 1'b0;
    repeat (2) @(posedge eth_rxc);
    rst_n = 1'b1;
    repeat (4) @(posedge eth_rxc);
    exp_b.delete(); exp_n.delete(); exp_len.delete(); exp_err.delete();
    model_drop = 0;
    chk_stream = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int npre, plen, er_idx, sel;
      logic [7:0] sfd;
      npre = $urandom_range(0, 10);
      sfd  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'hD5;
      sel  = $urandom_range(0, 9);
      plen = (sel == 0) ? $urandom_range(0, 3) :
             (sel == 1) ? $urandom_range(1518, 1530) : $urandom_range(30, 120);
      er_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, plen) : -1;
      make_pay(plen, er_idx, 1'b1, $urandom_range(0, 1) == 1);
      build_wire(npre, sfd);
      model_push();
      drive($urandom_range(1, 4));
    end
    for (int t = 0; t < 200 && exp_n.size() != 0; t++) @(posedge eth_rxc);
    check("rand_drain", exp_n.size(), 0);
    check("rand_drop", rx_drop_cnt, model_drop);
    chk_stream = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
